// File: rtl/spi_frame_pkg.sv
// spi_frame_pkg: op encodings, frame geometry and FSM states for the SPI frame master
package spi_frame_pkg;
  localparam int FRAME_W = 10;
  localparam int DATA_W = 8;
  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;
  typedef enum logic [2:0] {IDLE, LEAD, SHIFT, WAIT, CAPTURE, GAP} state_e;
  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a > b ? a : b;
    m = m > c ? m : c;
    return m > d ? m : d;
  endfunction
endpackage

// File: rtl/spi_frame_master.sv
// spi_frame_master: host-side SPI master sending {op,payload} frames and capturing RD_DATA bytes; SPI_FRAME_MASTER_STATS_EN adds wr_cnt/rd_cnt
module spi_frame_master
  import spi_frame_pkg::*;
#(
  parameter int LEAD_CYC = 2,
  parameter int RD_WAIT = 1,
  parameter int GAP_CYC = 1,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_payload,
  output logic              ss_n,
  output logic              mosi,
  input  logic              miso,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              done,
`ifdef SPI_FRAME_MASTER_STATS_EN
  output logic [CNT_W-1:0]  wr_cnt,
  output logic [CNT_W-1:0]  rd_cnt,
`endif
  output logic              busy
);
  localparam int CW = $clog2(max4(LEAD_CYC, RD_WAIT, GAP_CYC, FRAME_W) + 1);
  state_e state_q, state_d, after_idle, after_shift, after_cap;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0] op_q, op_d;
  logic [FRAME_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] rx_q, rx_d, rd_data_q, rd_data_d;
  logic ss_n_q, ss_n_d, mosi_q, mosi_d, rd_valid_q, rd_valid_d, last;
  always_comb begin
    after_idle = LEAD_CYC > 0 ? LEAD : SHIFT;
    after_cap = GAP_CYC > 0 ? GAP : IDLE;
    after_shift = op_q != OP_RD_DATA ? after_cap : RD_WAIT > 0 ? WAIT : CAPTURE;
    last = state_q == LEAD ? cnt_q == CW'(LEAD_CYC - 1) :
           state_q == SHIFT ? cnt_q == CW'(FRAME_W - 1) :
           state_q == WAIT ? cnt_q == CW'(RD_WAIT - 1) :
           state_q == CAPTURE ? cnt_q == CW'(DATA_W - 1) :
           state_q == GAP ? cnt_q == CW'(GAP_CYC - 1) : 1'b0;
    state_d = state_q;
    cnt_d = (last || state_q == IDLE) ? '0 : cnt_q + 1'b1;
    op_d = op_q;
    tx_d = state_q == SHIFT ? tx_q << 1 : tx_q;
    rx_d = state_q == CAPTURE ? {rx_q[DATA_W-2:0], miso} : rx_q;
    rd_valid_d = state_q == CAPTURE && last;
    rd_data_d = rd_valid_d ? rx_d : rd_data_q;
    if (state_q == IDLE && cmd_valid) begin
      state_d = after_idle;
      op_d = cmd_op;
      tx_d = {cmd_op, cmd_payload};
    end else if (last) begin
      state_d = state_q == LEAD ? SHIFT :
                state_q == SHIFT ? after_shift :
                state_q == WAIT ? CAPTURE :
                state_q == CAPTURE ? after_cap : IDLE;
    end
    ss_n_d = state_d inside {IDLE, GAP};
    mosi_d = (state_d == LEAD || state_d == SHIFT) && tx_d[FRAME_W-1];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      op_q <= '0;
      tx_q <= '0;
      rx_q <= '0;
      rd_data_q <= '0;
      rd_valid_q <= 1'b0;
      ss_n_q <= 1'b1;
      mosi_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      op_q <= op_d;
      tx_q <= tx_d;
      rx_q <= rx_d;
      rd_data_q <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      ss_n_q <= ss_n_d;
      mosi_q <= mosi_d;
    end
  end
`ifdef SPI_FRAME_MASTER_STATS_EN
  logic [CNT_W-1:0] wr_cnt_q, rd_cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else if (done) begin
      if (!op_q[1] && !(&wr_cnt_q)) wr_cnt_q <= wr_cnt_q + 1'b1;
      if (op_q[1] && !(&rd_cnt_q)) rd_cnt_q <= rd_cnt_q + 1'b1;
    end
  end
  assign wr_cnt = wr_cnt_q;
  assign rd_cnt = rd_cnt_q;
`endif
  assign done = state_q != IDLE && state_d == IDLE;
  assign cmd_ready = state_q == IDLE;
  assign busy = state_q != IDLE;
  assign ss_n = ss_n_q;
  assign mosi = mosi_q;
  assign rd_data = rd_data_q;
  assign rd_valid = rd_valid_q;
endmodule

// File: tb/tb_spi_frame_master.sv
// tb_spi_frame_master: directed scoreboard bench with a behavioural SPI slave on ss_n/mosi/miso
module tb_spi_frame_master;
  logic clk = 1'b0, rst_n = 1'b0, cmd_valid = 1'b0, miso = 1'b0;
  logic [1:0] cmd_op = '0;
  logic [7:0] cmd_payload = '0;
  logic cmd_ready, ss_n, mosi, rd_valid, done, busy;
  logic [7:0] rd_data;
`ifdef SPI_FRAME_MASTER_STATS_EN
  logic [1:0] wr_cnt, rd_cnt;
`endif
  int n_chk = 0, n_fail = 0, n_done = 0, n_rdv = 0, lo = 0, hi = 0, e_wr = 0, e_rd = 0;
  bit seen = 0;
  logic [9:0] rxf = '0, f;
  logic [1:0] lead = '0;
  logic [7:0] ram [256];
  logic [7:0] wa = '0, ra = '0, rbyte = '0, r;
  logic [9:0] sb [$];
  logic [7:0] rexp [$];
  spi_frame_master #(.CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_payload(cmd_payload), .ss_n(ss_n), .mosi(mosi),
    .miso(miso), .rd_data(rd_data), .rd_valid(rd_valid), .done(done),
`ifdef SPI_FRAME_MASTER_STATS_EN
    .wr_cnt(wr_cnt), .rd_cnt(rd_cnt),
`endif
    .busy(busy));
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "time limit");
  end
  always @(negedge clk) begin
    if (!rst_n) begin
      if (lo != 0 && sb.size() != 0) sb.delete(0);
      lo = 0; hi = 0; seen = 0; miso = 1'b0;
    end else begin
      if (done) n_done++;
      if (rd_valid) begin
        n_rdv++;
        n_chk++; if (rexp.size() == 0) begin n_fail++; $error("FAIL rd_q: no expected read"); end
        if (rexp.size() > 0) begin
          r = rexp.pop_front();
          n_chk++; if (rd_data !== r) begin n_fail++; $error("FAIL rd_data: observed %0h expected %0h", rd_data, r); end
        end
      end
      if (!ss_n) begin
        if (lo == 0 && seen) begin
          n_chk++; if (hi < 2) begin n_fail++; $error("FAIL gap: observed %0d", hi); end
        end
        if (lo < 2) lead = {lead[0], mosi};
        else if (lo < 12) rxf = {rxf[8:0], mosi};
        if (lo == 12 && rxf[9:8] == 2'b11) rbyte = ram[ra];
        miso = (lo >= 13 && lo <= 20) ? rbyte[3'(20 - lo)] : 1'b0;
        lo++;
      end else if (lo != 0) begin
        n_chk++; if (sb.size() == 0) begin n_fail++; $error("FAIL sb_q: unexpected frame"); end
        if (sb.size() > 0) begin
          f = sb.pop_front();
          n_chk++; if (rxf !== f) begin n_fail++; $error("FAIL frame: observed %0h expected %0h", rxf, f); end
          n_chk++; if (lead !== {2{f[9]}}) begin n_fail++; $error("FAIL lead: observed %0h expected %0h", lead, {2{f[9]}}); end
          n_chk++; if (lo != ((f[9:8] == 2'b11) ? 21 : 12)) begin n_fail++; $error("FAIL ss_len: observed %0d", lo); end
        end
        case (rxf[9:8])
          2'b00: wa = rxf[7:0];
          2'b01: ram[wa] = rxf[7:0];
          2'b10: ra = rxf[7:0];
          default: ;
        endcase
        lo = 0; hi = 1; seen = 1; miso = 1'b0;
      end else hi++;
    end
  end
  task automatic send(input logic [1:0] op, input logic [7:0] pl, input bit hold);
    int n = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_payload = pl;
    while (!cmd_ready && n < 400) begin @(negedge clk); n++; end
    n_chk++; if (n >= 400) begin n_fail++; $error("FAIL accept_to"); end
    sb.push_back({op, pl});
    if (op[1]) e_rd++; else e_wr++;
    @(negedge clk);
    n_chk++; if (cmd_ready !== 1'b0) begin n_fail++; $error("FAIL rdy_drop: observed %0h", cmd_ready); end
    n_chk++; if (busy !== 1'b1) begin n_fail++; $error("FAIL busy: observed %0h", busy); end
    if (!hold) cmd_valid = 1'b0;
  endtask
  task automatic wait_done(input int t);
    int n = 0;
    while (n_done < t && n < 400) begin @(negedge clk); n++; end
    n_chk++; if (n_done < t) begin n_fail++; $error("FAIL done_to: observed %0d expected %0d", n_done, t); end
    @(negedge clk);
    n_chk++; if (n_done != t) begin n_fail++; $error("FAIL done_cnt: observed %0d expected %0d", n_done, t); end
  endtask
  initial begin
    int d0, r0, n;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_chk++; if (ss_n !== 1'b1) begin n_fail++; $error("FAIL rst_ss_n: observed %0h", ss_n); end
    n_chk++; if (mosi !== 1'b0) begin n_fail++; $error("FAIL rst_mosi: observed %0h", mosi); end
    n_chk++; if (rd_data !== 8'h00) begin n_fail++; $error("FAIL rst_rd_data: observed %0h", rd_data); end
    n_chk++; if (rd_valid !== 1'b0) begin n_fail++; $error("FAIL rst_rd_valid: observed %0h", rd_valid); end
    n_chk++; if (done !== 1'b0) begin n_fail++; $error("FAIL rst_done: observed %0h", done); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $error("FAIL rst_busy: observed %0h", busy); end
    n_chk++; if (cmd_ready !== 1'b1) begin n_fail++; $error("FAIL rst_ready: observed %0h", cmd_ready); end
    d0 = n_done; r0 = n_rdv;
    send(2'b00, 8'h0F, 0); wait_done(d0 + 1);
    n_chk++; if (n_rdv != r0) begin n_fail++; $error("FAIL wr_no_rdv: observed %0d", n_rdv); end
    send(2'b01, 8'h53, 0); wait_done(d0 + 2);
    send(2'b10, 8'h0F, 0); wait_done(d0 + 3);
    rexp.push_back(8'h53);
    send(2'b11, 8'h0F, 0); wait_done(d0 + 4);
    n_chk++; if (n_rdv != r0 + 1) begin n_fail++; $error("FAIL rdv_cnt1: observed %0d", n_rdv); end
    send(2'b00, 8'hA5, 0); wait_done(d0 + 5);
    send(2'b01, 8'hC3, 0); wait_done(d0 + 6);
    send(2'b10, 8'hA5, 0); wait_done(d0 + 7);
    rexp.push_back(8'hC3);
    send(2'b11, 8'hA5, 0); wait_done(d0 + 8);
    send(2'b00, 8'h11, 1);
    send(2'b01, 8'h22, 1);
    send(2'b00, 8'h33, 1);
    send(2'b01, 8'h44, 0);
    wait_done(d0 + 12);
    n_chk++; if (rd_data !== 8'hC3) begin n_fail++; $error("FAIL rd_hold: observed %0h", rd_data); end
    send(2'b10, 8'h11, 0); wait_done(d0 + 13);
    rexp.push_back(8'h22);
    send(2'b11, 8'h11, 0); wait_done(d0 + 14);
`ifdef SPI_FRAME_MASTER_STATS_EN
    n_chk++; if (wr_cnt !== 2'(e_wr > 3 ? 3 : e_wr)) begin n_fail++; $error("FAIL wr_cnt_sat: observed %0h", wr_cnt); end
    n_chk++; if (rd_cnt !== 2'(e_rd > 3 ? 3 : e_rd)) begin n_fail++; $error("FAIL rd_cnt_sat: observed %0h", rd_cnt); end
`endif
    d0 = n_done;
    send(2'b01, 8'hEE, 0);
    n = 0;
    while (ss_n && n < 50) begin @(negedge clk); n++; end
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (ss_n !== 1'b1) begin n_fail++; $error("FAIL abort_ss_n: observed %0h", ss_n); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $error("FAIL abort_busy: observed %0h", busy); end
    n_chk++; if (done !== 1'b0) begin n_fail++; $error("FAIL abort_done: observed %0h", done); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    e_wr = 0; e_rd = 0;
    @(negedge clk);
    n_chk++; if (cmd_ready !== 1'b1) begin n_fail++; $error("FAIL post_rst_ready: observed %0h", cmd_ready); end
    n_chk++; if (n_done != d0) begin n_fail++; $error("FAIL abort_no_done: observed %0d", n_done); end
    send(2'b00, 8'h3C, 0); wait_done(d0 + 1);
    send(2'b10, 8'h33, 0); wait_done(d0 + 2);
    rexp.push_back(8'h44);
    send(2'b11, 8'h33, 0); wait_done(d0 + 3);
`ifdef SPI_FRAME_MASTER_STATS_EN
    n_chk++; if (wr_cnt !== 2'(e_wr)) begin n_fail++; $error("FAIL wr_cnt: observed %0h", wr_cnt); end
    n_chk++; if (rd_cnt !== 2'(e_rd)) begin n_fail++; $error("FAIL rd_cnt: observed %0h", rd_cnt); end
`endif
    n_chk++; if (n_rdv != 4) begin n_fail++; $error("FAIL rdv_total: observed %0d", n_rdv); end
    n_chk++; if (rexp.size() != 0) begin n_fail++; $error("FAIL rexp_empty: observed %0d", rexp.size()); end
    n_chk++; if (sb.size() != 0) begin n_fail++; $error("FAIL sb_empty: observed %0d", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
